// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and width helpers for the N-channel cacheline arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  // Cacheline width in bits for a given line-offset width.
  function automatic int calcLw(input int sOffset);
    return (2 ** sOffset) * 8;
  endfunction

  // Channel-index width; never narrower than one bit so a single channel still has a usable index.
  function automatic int calcCw(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Channel-side and adaptor-side buses of the arbiter, named from the arbiter's point of view.
interface mem_arbiter_n_if
  import arb_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int num_ch   = 2
);
  localparam int LW = calcLw(s_offset);

  logic [num_ch-1:0]    ch_read_i;
  logic [num_ch-1:0]    ch_write_i;
  logic [num_ch*32-1:0] ch_address_i;
  logic [num_ch*LW-1:0] ch_line_i;
  logic [LW-1:0]        ch_line_o;
  logic [num_ch-1:0]    ch_resp_o;
  logic [num_ch-1:0]    grant_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic [31:0]          mem_address_o;
  logic [LW-1:0]        mem_line_o;
  logic [LW-1:0]        mem_line_i;
  logic                 mem_resp_i;

  // Requesters and adaptor together: they drive every *_i signal.
  modport master (
    output ch_read_i, ch_write_i, ch_address_i, ch_line_i, mem_line_i, mem_resp_i,
    input  ch_line_o, ch_resp_o, grant_o, mem_read_o, mem_write_o, mem_address_o, mem_line_o
  );

  // The arbiter itself.
  modport slave (
    input  ch_read_i, ch_write_i, ch_address_i, ch_line_i, mem_line_i, mem_resp_i,
    output ch_line_o, ch_resp_o, grant_o, mem_read_o, mem_write_o, mem_address_o, mem_line_o
  );

endinterface

// File: rtl/mem_arbiter_n_rr_picker.sv
// Combinational winner selection: fixed priority or round-robin starting after a base pointer.
module rr_picker
  import arb_pkg::*;
#(
  parameter int num_ch  = 2,
  parameter int rr_mode = 1,
  localparam int CW     = calcCw(num_ch)
) (
  input  logic [num_ch-1:0] req_i,
  input  logic [CW-1:0]     base_i,
  output logic              valid_o,
  output logic [CW-1:0]     idx_o
);

  logic [CW-1:0] lowIdx;
  logic [CW-1:0] highIdx;
  logic          lowFound;
  logic          highFound;

  // Lowest requester overall, and lowest requester strictly above the base pointer (the wrap-free part of the rr scan).
  always_comb begin
    lowIdx    = '0;
    highIdx   = '0;
    lowFound  = 1'b0;
    highFound = 1'b0;
    for (int i = 0; i < num_ch; i++) begin
      if (req_i[i] && !lowFound) begin
        lowIdx   = CW'(i);
        lowFound = 1'b1;
      end
      if (req_i[i] && !highFound && (i > int'(base_i))) begin
        highIdx   = CW'(i);
        highFound = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;
  // With nobody above the pointer the scan wraps, which is just the lowest requester; one channel always yields 0.
  assign idx_o   = ((rr_mode != 0) && (num_ch > 1) && highFound) ? highIdx : lowIdx;

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel cacheline arbiter in front of a single adaptor; one line transaction in flight at a time.
module mem_arbiter_n
  import arb_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int num_ch   = 2,
  parameter int rr_mode  = 1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_n_if.slave bus
);

  localparam int LW = calcLw(s_offset);
  localparam int CW = calcCw(num_ch);

  arb_state_t        state_q;
  logic [CW-1:0]     winner_q;
  logic [CW-1:0]     ptr_q;
  logic [num_ch-1:0] grant_q;
  logic [num_ch-1:0] resp_q;
  logic              memRead_q;
  logic              memWrite_q;
  logic [31:0]       memAddress_q;
  logic [LW-1:0]     memLine_q;
  logic [LW-1:0]     chLine_q;

  logic [num_ch-1:0] chReq;
  logic              pickValid;
  logic [CW-1:0]     pickIdx;
  logic [31:0]       pickAddress_d;
  logic [LW-1:0]     pickLine_d;
  logic              pickWrite_d;
  logic [num_ch-1:0] pickGrant_d;

  assign chReq = bus.ch_read_i | bus.ch_write_i;

  rr_picker #(
    .num_ch (num_ch),
    .rr_mode(rr_mode)
  ) picker (
    .req_i  (chReq),
    .base_i (ptr_q),
    .valid_o(pickValid),
    .idx_o  (pickIdx)
  );

  // Pull the winner's address, write line and op out of the flat channel buses; write beats read.
  always_comb begin
    pickAddress_d = '0;
    pickLine_d    = '0;
    pickWrite_d   = 1'b0;
    pickGrant_d   = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (pickIdx == CW'(i)) begin
        pickAddress_d  = bus.ch_address_i[32*i +: 32];
        pickLine_d     = bus.ch_line_i[LW*i +: LW];
        pickWrite_d    = bus.ch_write_i[i];
        pickGrant_d[i] = 1'b1;
      end
    end
  end

  // Transaction FSM with every output registered; the rr pointer moves only when a transaction completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      ptr_q        <= CW'(num_ch - 1);
      grant_q      <= '0;
      resp_q       <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      memAddress_q <= '0;
      memLine_q    <= '0;
      chLine_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= '0;
          if (pickValid) begin
            winner_q     <= pickIdx;
            grant_q      <= pickGrant_d;
            memAddress_q <= pickAddress_d;
            memLine_q    <= pickLine_d;
            memWrite_q   <= pickWrite_d;
            memRead_q    <= !pickWrite_d;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp_i) begin
            chLine_q   <= bus.mem_line_i;
            ptr_q      <= winner_q;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            resp_q     <= grant_q;
            state_q    <= RESP;
          end
        end
        RESP: begin
          resp_q       <= '0;
          grant_q      <= '0;
          memAddress_q <= '0;
          memLine_q    <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ch_line_o     = chLine_q;
  assign bus.ch_resp_o     = resp_q;
  assign bus.grant_o       = grant_q;
  assign bus.mem_read_o    = memRead_q;
  assign bus.mem_write_o   = memWrite_q;
  assign bus.mem_address_o = memAddress_q;
  assign bus.mem_line_o    = memLine_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a round-robin 2-channel instance and a fixed-priority 3-channel instance.
module tb_mem_arbiter_n;
  import arb_pkg::*;

  localparam int SOFF = 5;
  localparam int LW   = calcLw(SOFF);

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic        wr;
    logic [LW-1:0] wline;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic selFx = 1'b0;
  exp_t sbQ[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter_n_if #(.s_offset(SOFF), .num_ch(2)) busRr ();
  mem_arbiter_n_if #(.s_offset(SOFF), .num_ch(3)) busFx ();

  mem_arbiter_n #(.s_offset(SOFF), .num_ch(2), .rr_mode(1)) dutRr (
    .clk(clk), .rst(rst), .bus(busRr.slave)
  );
  mem_arbiter_n #(.s_offset(SOFF), .num_ch(3), .rr_mode(0)) dutFx (
    .clk(clk), .rst(rst), .bus(busFx.slave)
  );

  // Outputs of whichever instance is currently under test, widened to common sizes.
  logic          obsRd, obsWr;
  logic [31:0]   obsAddr;
  logic [LW-1:0] obsMemLine, obsChLine;
  logic [7:0]    obsGrant, obsResp;
  assign obsRd      = selFx ? busFx.mem_read_o    : busRr.mem_read_o;
  assign obsWr      = selFx ? busFx.mem_write_o   : busRr.mem_write_o;
  assign obsAddr    = selFx ? busFx.mem_address_o : busRr.mem_address_o;
  assign obsMemLine = selFx ? busFx.mem_line_o    : busRr.mem_line_o;
  assign obsChLine  = selFx ? busFx.ch_line_o     : busRr.ch_line_o;
  assign obsGrant   = selFx ? 8'(busFx.grant_o)   : 8'(busRr.grant_o);
  assign obsResp    = selFx ? 8'(busFx.ch_resp_o) : 8'(busRr.ch_resp_o);

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expVal);
    compared++;
    if (obs !== expVal) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expVal);
    end
  endtask

  function automatic logic [LW-1:0] lineFor(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [LW-1:0] line);
    if (selFx) begin
      busFx.ch_read_i[ch] = rd;
      busFx.ch_write_i[ch] = wr;
      busFx.ch_address_i[32*ch +: 32] = addr;
      busFx.ch_line_i[LW*ch +: LW] = line;
    end else begin
      busRr.ch_read_i[ch] = rd;
      busRr.ch_write_i[ch] = wr;
      busRr.ch_address_i[32*ch +: 32] = addr;
      busRr.ch_line_i[LW*ch +: LW] = line;
    end
  endtask

  task automatic expectTxn(input int ch, input logic [31:0] addr, input logic wr, input logic [LW-1:0] wline);
    exp_t e;
    e.ch = ch;
    e.addr = addr;
    e.wr = wr;
    e.wline = wline;
    sbQ.push_back(e);
  endtask

  task automatic dropAll();
    busRr.ch_read_i = '0;
    busRr.ch_write_i = '0;
    busRr.ch_address_i = '0;
    busRr.ch_line_i = '0;
    busFx.ch_read_i = '0;
    busFx.ch_write_i = '0;
    busFx.ch_address_i = '0;
    busFx.ch_line_i = '0;
  endtask

  task automatic driveResp(input logic v, input logic [LW-1:0] l);
    if (selFx) begin
      busFx.mem_resp_i = v;
      busFx.mem_line_i = l;
    end else begin
      busRr.mem_resp_i = v;
      busRr.mem_line_i = l;
    end
  endtask

  // Adaptor model: wait for a memory op, hold it for `delay` busy cycles, answer, then check the response.
  task automatic serve(input int delay);
    exp_t e;
    int waitCnt;
    logic [LW-1:0] rl;
    waitCnt = 0;
    while (!(obsRd || obsWr) && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!(obsRd || obsWr)) begin
      checkOutput("busyTimeout", 0, 1);
      return;
    end
    if (sbQ.size() == 0) begin
      checkOutput("sbUnderflow", 0, 1);
      return;
    end
    e = sbQ.pop_front();
    for (int c = 0; c < delay; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("grant", obsGrant, 1 << e.ch);
      checkOutput("memAddr", obsAddr, e.addr);
      checkOutput("memOp", {obsWr, obsRd}, e.wr ? 2'b10 : 2'b01);
      checkOutput("memLine", obsMemLine, e.wline);
      checkOutput("busyResp", obsResp, 0);
    end
    rl = lineFor(e.addr);
    driveResp(1'b1, rl);
    @(negedge clk);
    driveResp(1'b0, '0);
    checkOutput("chResp", obsResp, 1 << e.ch);
    checkOutput("chLine", obsChLine, rl);
    checkOutput("respMemOff", {obsWr, obsRd}, 0);
    checkOutput("respGrant", obsGrant, 1 << e.ch);
    @(negedge clk);
    checkOutput("respPulse", obsResp, 0);
    checkOutput("grantClear", obsGrant, 0);
    checkOutput("lineHold", obsChLine, rl);
  endtask

  // Bounded run time so a stuck design still ends the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, round-robin, latency, write, read+write, reset mid-busy, fixed priority.
  initial begin
    int waitCnt;
    exp_t e;
    dropAll();
    busRr.mem_resp_i = 1'b0;
    busRr.mem_line_i = '0;
    busFx.mem_resp_i = 1'b0;
    busFx.mem_line_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      selFx = (s == 1);
      #1;
      checkOutput("rstGrant", obsGrant, 0);
      checkOutput("rstResp", obsResp, 0);
      checkOutput("rstMemOp", {obsWr, obsRd}, 0);
      checkOutput("rstAddr", obsAddr, 0);
      checkOutput("rstChLine", obsChLine, 0);
    end
    selFx = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] round-robin with two continuous readers");
    applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
    applyStimulus(1, 1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 4; k++) expectTxn(k % 2, (k % 2 == 0) ? 32'h100 : 32'h200, 1'b0, '0);
    for (int k = 0; k < 4; k++) serve(2);
    dropAll();

    $display("[TB] latency of a single read");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h500, '0);
    expectTxn(0, 32'h500, 1'b0, '0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc <= 5) begin
        checkOutput($sformatf("latRd%0d", cyc), obsRd, 1);
        checkOutput($sformatf("latGrant%0d", cyc), obsGrant, 1);
      end
      if (cyc == 5) driveResp(1'b1, lineFor(32'h500));
      if (cyc == 6) begin
        driveResp(1'b0, '0);
        if (sbQ.size() == 0) checkOutput("latSb", 0, 1);
        else begin
          e = sbQ.pop_front();
          checkOutput("latResp", obsResp, 1 << e.ch);
          checkOutput("latLine", obsChLine, lineFor(e.addr));
        end
        checkOutput("latRdOff", obsRd, 0);
        checkOutput("latGrantHeld", obsGrant, 1);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, '0);
      end
      if (cyc == 7) begin
        checkOutput("latGrantClr", obsGrant, 0);
        checkOutput("latRespOff", obsResp, 0);
      end
    end

    $display("[TB] write from channel 1");
    applyStimulus(1, 1'b0, 1'b1, 32'h40, {8{32'hDEADBEEF}});
    expectTxn(1, 32'h40, 1'b1, {8{32'hDEADBEEF}});
    serve(3);
    dropAll();

    $display("[TB] read and write together on one channel");
    applyStimulus(0, 1'b1, 1'b1, 32'h80, lineFor(32'h1234));
    expectTxn(0, 32'h80, 1'b1, lineFor(32'h1234));
    serve(2);
    dropAll();

    $display("[TB] reset in the middle of a busy transaction");
    applyStimulus(1, 1'b1, 1'b0, 32'h300, '0);
    waitCnt = 0;
    while (!obsRd && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midBusyRd", obsRd, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dropAll();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortGrant", obsGrant, 0);
    checkOutput("abortMemOp", {obsWr, obsRd}, 0);
    checkOutput("abortAddr", obsAddr, 0);
    checkOutput("abortResp", obsResp, 0);
    checkOutput("abortLine", obsChLine, 0);
    driveResp(1'b1, lineFor(32'h999));
    @(negedge clk);
    driveResp(1'b0, '0);
    checkOutput("strayResp", obsResp, 0);
    checkOutput("strayGrant", obsGrant, 0);
    @(negedge clk);
    checkOutput("strayResp2", obsResp, 0);
    checkOutput("strayLine", obsChLine, 0);
    applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
    applyStimulus(1, 1'b1, 1'b0, 32'h200, '0);
    expectTxn(0, 32'h100, 1'b0, '0);
    serve(2);
    dropAll();

    $display("[TB] fixed priority with channels 0 and 2 requesting");
    selFx = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h100, '0);
    applyStimulus(2, 1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 3; k++) expectTxn(0, 32'h100, 1'b0, '0);
    for (int k = 0; k < 3; k++) serve(1);
    dropAll();
    applyStimulus(2, 1'b1, 1'b0, 32'h200, '0);
    expectTxn(2, 32'h200, 1'b0, '0);
    serve(1);
    dropAll();
    @(negedge clk);

    checkOutput("sbDrain", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
